seq_spi_host: RTL and testbench
===============================

# seq_spi_host

Host-side SPI master and strobe generator that drives the motor sequencer's command port. It accepts 32-bit command words over a valid/ready handshake and serialises each one MSB-first on `sclk`/`mosi` under `ss_n`. After each frame it pulses `latch_data` so the sequencer's system controller commits the word. It also issues `control_trigger` pulses on request. The block sits in the test/host FPGA or on the harness side, facing the sequencer chip's `sclk`, `mosi`, `ss_n`, `miso`, `latch_data` and `control_trigger` pins.

## Interface
- `CLK_DIV`, 4: `clock` cycles per SCLK half-period; legal range 1..255.
- `LATCH_CYCLES`, 2: width of the `latch_data` pulse in `clock` cycles; legal range 1..15.
- `clock`  input  1  system clock; all logic is on the rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `cmd_data`  input  32  command word to transmit.
- `cmd_valid`  input  1  `cmd_data` is valid.
- `cmd_ready`  output  1  block can accept a word; a word transfers on a cycle where `cmd_valid && cmd_ready`.
- `trigger_req`  input  1  single-cycle request for one `control_trigger` pulse.
- `busy`  output  1  high in any state other than IDLE, or while a trigger is pending.
- `rx_data`  output  32  word shifted in on `miso` during the last frame.
- `rx_valid`  output  1  one-cycle pulse; `rx_data` is updated.
- `sclk`  output  1  SPI clock, mode 0 (idle low).
- `mosi`  output  1  SPI data out, MSB first.
- `ss_n`  output  1  SPI select, active low.
- `miso`  input  1  SPI data in.
- `latch_data`  output  1  commit strobe to the sequencer.
- `control_trigger`  output  1  one-cycle trigger pulse to the sequencer.

## Operation
- **Reset values:** `sclk`=0, `mosi`=0, `ss_n`=1, `latch_data`=0, `control_trigger`=0, `rx_valid`=0, `rx_data`=0, `cmd_ready`=0 during reset, `busy`=0, trigger pending flag cleared.
- **States:** IDLE, SETUP, HIGH, LOW, DESELECT, LATCH.
  - A half-period counter counts `CLK_DIV` cycles per timed state.
  - A 6-bit bit counter counts rising SCLK edges, 0..32.
- **IDLE:**
  - `cmd_ready`=1 unless a trigger is pending.
  - If a trigger is pending, drive `control_trigger`=1 for one cycle and clear the pending flag. `cmd_ready`=0 in that cycle, so a trigger has priority over a simultaneous command.
  - Otherwise, on a handshake: capture `cmd_data` into the shift register, drive `mosi`=bit31, set `ss_n`=0, go to SETUP.
- **SETUP:** `sclk`=0 for `CLK_DIV` cycles, then go to HIGH.
- **HIGH:**
  - Set `sclk`=1 and sample `miso` into the LSB of the rx shift register on entry.
  - Increment the bit counter.
  - Stay for `CLK_DIV` cycles, then go to LOW.
- **LOW:**
  - Set `sclk`=0.
  - If the bit counter is below 32, shift TX left, present the next bit on `mosi`, and go to HIGH after `CLK_DIV` cycles.
  - If the bit counter is 32, go to DESELECT after `CLK_DIV` cycles.
- **DESELECT:**
  - On entry: `ss_n`=1, `mosi`=0, `rx_data` loaded from the rx shift register, `rx_valid` pulsed for one cycle.
  - Hold `CLK_DIV` cycles, then go to LATCH.
- **LATCH:** `latch_data`=1 for exactly `LATCH_CYCLES` cycles, then return to IDLE.
- **Trigger requests:**
  - `trigger_req` in any state sets the pending flag.
  - Multiple requests before service collapse into one pulse.
  - A request arriving in the same cycle a pulse is issued re-sets the flag, giving a second pulse on the next IDLE cycle.
- **Counter rules:** the half-period counter is 8 bits, reloaded to `CLK_DIV-1` on each state entry; the state advances when it reaches 0.
- **Reset mid-frame:** the frame is aborted with no `latch_data` and no `rx_valid`. Outputs return to reset values on the clock edge after `reset` is sampled high. The captured word is discarded.
- **Handshake stability:** `cmd_data` and `cmd_valid` changing while `cmd_ready`=0 have no effect.

## Timing
- Handshake on edge t0 (the word transfers at this clock edge). Times below are cycle indices counted from that edge.
- `ss_n` falls at t0+1 with `mosi`=bit31 valid.
- The rising SCLK edge for bit k (k=31..0, MSB first) occurs at t0+1+CLK_DIV·(1+2·(31−k)).
- `mosi` changes only while `sclk` is low, and is stable ≥`CLK_DIV` cycles around each rising edge.
- `ss_n` rises at t0+1+65·CLK_DIV. `rx_valid` is high in that same cycle.
- `latch_data` is high over t0+1+66·CLK_DIV .. t0+66·CLK_DIV+LATCH_CYCLES.
- `cmd_ready` returns high in the next cycle, when the block is back in IDLE.
- Frame period for back-to-back words: 66·CLK_DIV+LATCH_CYCLES+1 cycles.
- `control_trigger` fires in the first IDLE cycle after the request, i.e. 1 cycle after `trigger_req` when idle.

## Test plan
- **Reset values:** assert `reset` for 3 cycles, then release -> all outputs at reset values; `cmd_ready`=1 on the first cycle after release.
- **Single frame, CLK_DIV=4, LATCH_CYCLES=2:** send 0xA5C3_0F81 at t0 ->
  - `ss_n` low at t0+1; first `sclk` rise at t0+5; 32 rises, 8 cycles apart.
  - `mosi` bits match 0xA5C3_0F81 MSB first.
  - `ss_n` high at t0+261; `latch_data` high at t0+265..266; `cmd_ready` high at t0+267.
- **Loopback:** tie `miso` to `mosi`, send 0x1234_5678 -> `rx_valid` pulses at `ss_n` rise with `rx_data`=0x1234_5678.
- **Back-to-back frames:** hold `cmd_valid` high with two words, CLK_DIV=1 -> second `ss_n` fall exactly 69 cycles after the first; no handshake while `busy`.
- **Trigger arbitration:**
  - `trigger_req` mid-frame -> one `control_trigger` pulse in the first IDLE cycle after LATCH, before a waiting command is accepted.
  - Two requests mid-frame -> still one pulse.
- **Reset abort:** assert `reset` at bit 10 of a frame -> `ss_n`=1 and `sclk`=0 the next cycle; no `latch_data` and no `rx_valid` ever follow.

Source files
------------

// File: rtl/seq_spi_host_if.sv
// -----------------------------------------------------------------------------
// seq_spi_host_if
//
// Command/response port of the sequencer SPI host. Groups the word handshake,
// the trigger request and the receive side into one bundle.
//
// Signals:
//   cmd_data    [31:0]  command word to transmit
//   cmd_valid           cmd_data is valid
//   cmd_ready           host can accept a word (transfer on valid && ready)
//   trigger_req         single-cycle request for one control_trigger pulse
//   busy                host is mid-frame or has a trigger pending
//   rx_data     [31:0]  word shifted in on miso during the last frame
//   rx_valid            one-cycle pulse, rx_data updated
//
// Modports:
//   master  the user of the SPI host (drives commands, observes results)
//   slave   the SPI host itself
// -----------------------------------------------------------------------------
interface seq_spi_host_if;
    logic [31:0] cmd_data;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        trigger_req;
    logic        busy;
    logic [31:0] rx_data;
    logic        rx_valid;

    modport master (
        output cmd_data,
        output cmd_valid,
        output trigger_req,
        input  cmd_ready,
        input  busy,
        input  rx_data,
        input  rx_valid
    );

    modport slave (
        input  cmd_data,
        input  cmd_valid,
        input  trigger_req,
        output cmd_ready,
        output busy,
        output rx_data,
        output rx_valid
    );
endinterface

// File: rtl/seq_spi_host.sv
// -----------------------------------------------------------------------------
// seq_spi_host
//
// Host-side SPI master and strobe generator for the motor sequencer command
// port. Each accepted 32-bit word is shifted out MSB-first in SPI mode 0
// under ss_n, while miso is shifted in. After the frame ss_n is released,
// the received word is presented with a one-cycle rx_valid, and latch_data
// is pulsed so the sequencer commits the word. Independently, trigger
// requests are remembered and turned into a single control_trigger pulse on
// the next idle cycle, ahead of any waiting command.
//
// Parameters:
//   CLK_DIV       clock cycles per SCLK half-period (1..255)
//   LATCH_CYCLES  width of the latch_data pulse in clock cycles (1..15)
//
// Ports:
//   clock            system clock, rising edge
//   reset            synchronous active-high reset
//   cmd              command/response bundle (seq_spi_host_if.slave)
//   sclk             SPI clock, idle low
//   mosi             SPI data out, MSB first
//   ss_n             SPI select, active low
//   miso             SPI data in
//   latch_data       commit strobe to the sequencer
//   control_trigger  one-cycle trigger pulse to the sequencer
// -----------------------------------------------------------------------------
module seq_spi_host #(
    parameter int CLK_DIV      = 4,
    parameter int LATCH_CYCLES = 2
) (
    input  logic          clock,
    input  logic          reset,
    seq_spi_host_if.slave cmd,
    output logic          sclk,
    output logic          mosi,
    output logic          ss_n,
    input  logic          miso,
    output logic          latch_data,
    output logic          control_trigger
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        HIGH,
        LOW,
        DESELECT,
        LATCH
    } state_t;

    // Reload values for the shared state timer. Every timed state lasts
    // (reload + 1) cycles because the state advances when the timer is 0.
    localparam logic [7:0] DIV_RELOAD   = 8'(CLK_DIV - 1);
    localparam logic [7:0] LATCH_RELOAD = 8'(LATCH_CYCLES - 1);
    localparam logic [5:0] LAST_BIT     = 6'd32;

    state_t      state;
    state_t      state_next;
    logic [7:0]  half_cnt;
    logic [5:0]  bit_cnt;
    logic [31:0] tx_shift;
    logic [31:0] rx_shift;
    logic        trig_pending;
    logic        accept;
    logic        fire;
    logic        timer_done;
    logic        enter_high;
    logic        enter_low_shift;
    logic        enter_deselect;

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake decode. A pending trigger blocks cmd_ready in
    // IDLE so the trigger pulse always wins over a simultaneous command.
    always_comb begin
        state_next      = state;
        accept          = 1'b0;
        fire            = 1'b0;
        cmd.cmd_ready   = 1'b0;
        timer_done      = (half_cnt == 8'd0);

        case (state)
            IDLE: begin
                if (!reset) begin
                    if (trig_pending) begin
                        fire = 1'b1;
                    end else begin
                        cmd.cmd_ready = 1'b1;
                        if (cmd.cmd_valid) begin
                            accept     = 1'b1;
                            state_next = SETUP;
                        end
                    end
                end
            end
            SETUP: begin
                if (timer_done) begin
                    state_next = HIGH;
                end
            end
            HIGH: begin
                if (timer_done) begin
                    state_next = LOW;
                end
            end
            LOW: begin
                if (timer_done) begin
                    state_next = (bit_cnt == LAST_BIT) ? DESELECT : HIGH;
                end
            end
            DESELECT: begin
                if (timer_done) begin
                    state_next = LATCH;
                end
            end
            LATCH: begin
                if (timer_done) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        control_trigger = fire;
        cmd.busy        = (state != IDLE) || trig_pending;

        // Transition strobes used by the datapath.
        enter_high      = (state != HIGH) && (state_next == HIGH);
        enter_low_shift = (state == HIGH) && (state_next == LOW) && (bit_cnt < LAST_BIT);
        enter_deselect  = (state == LOW) && (state_next == DESELECT);
    end

    // State timer: reloaded on every state change, otherwise counts down to 0
    // and holds there until the FSM moves on.
    always_ff @(posedge clock) begin
        if (reset) begin
            half_cnt <= 8'd0;
        end else if (state_next != state) begin
            half_cnt <= (state_next == LATCH) ? LATCH_RELOAD : DIV_RELOAD;
        end else if (half_cnt != 8'd0) begin
            half_cnt <= half_cnt - 8'd1;
        end
    end

    // Trigger pending flag. A new request has priority over the clear, so a
    // request landing in the same cycle as a pulse yields a second pulse.
    always_ff @(posedge clock) begin
        if (reset) begin
            trig_pending <= 1'b0;
        end else begin
            trig_pending <= cmd.trigger_req | (trig_pending & ~fire);
        end
    end

    // SPI pins are registered from the next state so they change exactly on
    // the state transition edge and never glitch.
    always_ff @(posedge clock) begin
        if (reset) begin
            sclk       <= 1'b0;
            ss_n       <= 1'b1;
            latch_data <= 1'b0;
        end else begin
            sclk       <= (state_next == HIGH);
            ss_n       <= !(state_next inside {SETUP, HIGH, LOW});
            latch_data <= (state_next == LATCH);
        end
    end

    // Transmit path. The MSB is presented together with ss_n falling; later
    // bits are presented as SCLK falls, so mosi is settled a full half-period
    // before each rising edge. After the last bit nothing is shifted.
    always_ff @(posedge clock) begin
        if (reset) begin
            tx_shift <= 32'd0;
            mosi     <= 1'b0;
        end else if (accept) begin
            tx_shift <= cmd.cmd_data;
            mosi     <= cmd.cmd_data[31];
        end else if (enter_low_shift) begin
            tx_shift <= tx_shift << 1;
            mosi     <= tx_shift[30];
        end else if (enter_deselect) begin
            mosi     <= 1'b0;
        end
    end

    // Bit counter counts rising SCLK edges of the current frame (0..32).
    always_ff @(posedge clock) begin
        if (reset) begin
            bit_cnt <= 6'd0;
        end else if (accept) begin
            bit_cnt <= 6'd0;
        end else if (enter_high) begin
            bit_cnt <= bit_cnt + 6'd1;
        end
    end

    // Receive path: miso is sampled on the same edge that raises SCLK. The
    // assembled word is published as ss_n rises; an aborted frame never
    // reaches that point, so its partial word is dropped.
    always_ff @(posedge clock) begin
        if (reset) begin
            rx_shift     <= 32'd0;
            cmd.rx_data  <= 32'd0;
            cmd.rx_valid <= 1'b0;
        end else begin
            cmd.rx_valid <= 1'b0;
            if (enter_high) begin
                rx_shift <= {rx_shift[30:0], miso};
            end
            if (enter_deselect) begin
                cmd.rx_data  <= rx_shift;
                cmd.rx_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seq_spi_host.sv
// -----------------------------------------------------------------------------
// tb_seq_spi_host
//
// Self-checking bench for seq_spi_host. Two instances are used: one with
// CLK_DIV=4 / LATCH_CYCLES=2 for frame, trigger and reset scenarios, and one
// with CLK_DIV=1 / LATCH_CYCLES=2 for back-to-back framing. Expected pin
// waveforms are computed from the frame timing formulas relative to the
// handshake edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_seq_spi_host;

    localparam int D4 = 4;
    localparam int L4 = 2;
    localparam int D1 = 1;
    localparam int L1 = 2;

    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

    seq_spi_host_if bus4 ();
    seq_spi_host_if bus1 ();

    logic sclk4, mosi4, ss_n4, miso4, latch4, trig4;
    logic sclk1, mosi1, ss_n1, miso1, latch1, trig1;
    logic miso_rand;
    logic loop_en;

    int checks = 0;
    int errors = 0;

    assign miso4 = loop_en ? mosi4 : miso_rand;

    seq_spi_host #(.CLK_DIV(D4), .LATCH_CYCLES(L4)) dut4 (
        .clock           (clock),
        .reset           (reset),
        .cmd             (bus4),
        .sclk            (sclk4),
        .mosi            (mosi4),
        .ss_n            (ss_n4),
        .miso            (miso4),
        .latch_data      (latch4),
        .control_trigger (trig4)
    );

    seq_spi_host #(.CLK_DIV(D1), .LATCH_CYCLES(L1)) dut1 (
        .clock           (clock),
        .reset           (reset),
        .cmd             (bus1),
        .sclk            (sclk1),
        .mosi            (mosi1),
        .ss_n            (ss_n1),
        .miso            (miso1),
        .latch_data      (latch1),
        .control_trigger (trig1)
    );

    // Expected {ss_n, sclk, latch_data, rx_valid, cmd_ready, busy, trigger}
    // in cycle k after the handshake edge of an undisturbed frame.
    function automatic logic [6:0] expected_pins(input int k, input int d, input int l);
        logic ss, sc, la, rv, cr, bz;
        ss = !(k >= 1 && k <= 65 * d);
        sc = 1'b0;
        if (k >= 1 + d && k <= 65 * d) begin
            sc = (((k - 1 - d) / d) % 2) == 0;
        end
        la = (k >= 66 * d + 1) && (k <= 66 * d + l);
        rv = (k == 65 * d + 1);
        cr = (k == 66 * d + l + 1);
        bz = (k <= 66 * d + l);
        return {ss, sc, la, rv, cr, bz, 1'b0};
    endfunction

    // One complete frame on the CLK_DIV=4 instance with per-cycle pin checks.
    task automatic run_frame(input logic [31:0] word, input logic loopback, input string name);
        int          last;
        int          j;
        logic [31:0] rx_exp;
        logic [31:0] rx_want;
        logic [6:0]  got;
        logic [6:0]  want;
        last    = 66 * D4 + L4 + 1;
        rx_exp  = 32'd0;
        loop_en = loopback;
        @(negedge clock);
        checks++;
        if (bus4.cmd_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL %s_ready_before got=%b exp=1", name, bus4.cmd_ready);
        end
        bus4.cmd_data  = word;
        bus4.cmd_valid = 1'b1;
        @(posedge clock);
        for (int k = 1; k <= last; k++) begin
            @(negedge clock);
            if (k == 1) begin
                bus4.cmd_valid = 1'b0;
                bus4.cmd_data  = $urandom;
            end
            want = expected_pins(k, D4, L4);
            got  = {ss_n4, sclk4, latch4, bus4.rx_valid, bus4.cmd_ready, bus4.busy, trig4};
            checks++;
            if (got !== want) begin
                errors++;
                $display("[TB] FAIL %s_pins k=%0d got=%b exp=%b", name, k, got, want);
            end
            if (k >= 1 + D4 && ((k - 1 - D4) % (2 * D4)) == 0 && ((k - 1 - D4) / (2 * D4)) < 32) begin
                j = (k - 1 - D4) / (2 * D4);
                checks++;
                if (mosi4 !== word[31 - j]) begin
                    errors++;
                    $display("[TB] FAIL %s_mosi bit=%0d got=%b exp=%b", name, 31 - j, mosi4, word[31 - j]);
                end
                rx_exp[31 - j] = miso4;
            end
            if (k > 65 * D4) begin
                checks++;
                if (mosi4 !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL %s_mosi_idle k=%0d got=%b exp=0", name, k, mosi4);
                end
            end
            if (k == 65 * D4 + 1) begin
                rx_want = loopback ? word : rx_exp;
                checks++;
                if (bus4.rx_data !== rx_want) begin
                    errors++;
                    $display("[TB] FAIL %s_rx_data got=%h exp=%h", name, bus4.rx_data, rx_want);
                end
            end
            miso_rand = 1'($urandom_range(0, 1));
        end
        loop_en = 1'b0;
    endtask

    task automatic test_reset();
        logic [6:0] got;
        bus4.cmd_valid   = 1'b0;
        bus4.trigger_req = 1'b0;
        bus1.cmd_valid   = 1'b0;
        bus1.trigger_req = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        got = {sclk4, mosi4, ss_n4, latch4, trig4, bus4.rx_valid, bus4.busy};
        checks++;
        if (got !== 7'b0010000 || bus4.cmd_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_during pins=%b ready=%b exp pins=0010000 ready=0", got, bus4.cmd_ready);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (bus4.cmd_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_release_ready got=%b exp=1", bus4.cmd_ready);
        end
        @(negedge clock);
        got = {sclk4, mosi4, ss_n4, latch4, trig4, bus4.rx_valid, bus4.busy};
        checks++;
        if (got !== 7'b0010000 || bus4.rx_data !== 32'd0 || bus4.cmd_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_after pins=%b rx=%h ready=%b exp pins=0010000 rx=0 ready=1",
                     got, bus4.rx_data, bus4.cmd_ready);
        end
    endtask

    task automatic test_single_frame();
        run_frame(32'hA5C3_0F81, 1'b0, "single");
    endtask

    task automatic test_loopback();
        run_frame(32'h1234_5678, 1'b1, "loopback");
    endtask

    task automatic test_random_frames();
        for (int n = 0; n < 3; n++) begin
            run_frame($urandom, 1'($urandom_range(0, 1)), "random");
        end
    endtask

    task automatic test_trigger_idle();
        logic [2:0] got;
        @(negedge clock);
        bus4.trigger_req = 1'b1;
        @(negedge clock);
        got = {trig4, bus4.cmd_ready, bus4.busy};
        checks++;
        if (got !== 3'b101) begin
            errors++;
            $display("[TB] FAIL trig_first got=%b exp=101", got);
        end
        @(negedge clock);
        bus4.trigger_req = 1'b0;
        got = {trig4, bus4.cmd_ready, bus4.busy};
        checks++;
        if (got !== 3'b101) begin
            errors++;
            $display("[TB] FAIL trig_rearm got=%b exp=101", got);
        end
        @(negedge clock);
        got = {trig4, bus4.cmd_ready, bus4.busy};
        checks++;
        if (got !== 3'b010) begin
            errors++;
            $display("[TB] FAIL trig_done got=%b exp=010", got);
        end
    endtask

    task automatic test_trigger_midframe();
        int   p;
        int   trig_cnt;
        int   trig_idx;
        int   fall_idx;
        int   extra;
        logic prev_ss;
        logic done;
        p        = 66 * D4 + L4 + 1;
        trig_cnt = 0;
        trig_idx = -1;
        fall_idx = -1;
        extra    = 0;
        prev_ss  = 1'b0;
        @(negedge clock);
        bus4.cmd_data  = $urandom;
        bus4.cmd_valid = 1'b1;
        @(posedge clock);
        for (int k = 1; k <= p + 2; k++) begin
            @(negedge clock);
            if (k == 1) begin
                bus4.cmd_data = $urandom;
            end
            bus4.trigger_req = (k == 40) || (k == 120);
            if (trig4) begin
                trig_cnt++;
                trig_idx = k;
            end
            if (prev_ss && !ss_n4) begin
                fall_idx = k;
            end
            prev_ss = ss_n4;
            if (k == p) begin
                checks++;
                if ({trig4, bus4.cmd_ready} !== 2'b10) begin
                    errors++;
                    $display("[TB] FAIL trigmid_priority got=%b exp=10", {trig4, bus4.cmd_ready});
                end
            end
            if (k == p + 2) begin
                bus4.cmd_valid = 1'b0;
            end
        end
        checks++;
        if (trig_cnt != 1 || trig_idx != p) begin
            errors++;
            $display("[TB] FAIL trigmid_pulse count=%0d at=%0d exp count=1 at=%0d", trig_cnt, trig_idx, p);
        end
        checks++;
        if (fall_idx != p + 2) begin
            errors++;
            $display("[TB] FAIL trigmid_next_frame got=%0d exp=%0d", fall_idx, p + 2);
        end
        done = 1'b0;
        for (int c = 0; c < 400 && !done; c++) begin
            @(negedge clock);
            if (trig4) extra++;
            if (bus4.cmd_ready) done = 1'b1;
        end
        checks++;
        if (!done || extra != 0) begin
            errors++;
            $display("[TB] FAIL trigmid_tail done=%b extra=%0d exp done=1 extra=0", done, extra);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] word_a;
        logic [31:0] word_b;
        logic [31:0] got_w [2];
        int          falls [2];
        int          nf;
        int          viol;
        logic        prev_ss;
        logic        prev_sc;
        word_a   = $urandom;
        word_b   = $urandom;
        got_w[0] = 32'd0;
        got_w[1] = 32'd0;
        falls[0] = -1;
        falls[1] = -1;
        nf       = 0;
        viol     = 0;
        prev_ss  = 1'b1;
        prev_sc  = 1'b0;
        @(negedge clock);
        checks++;
        if (bus1.cmd_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL b2b_ready_before got=%b exp=1", bus1.cmd_ready);
        end
        bus1.cmd_data  = word_a;
        bus1.cmd_valid = 1'b1;
        for (int c = 1; c <= 170; c++) begin
            @(negedge clock);
            if (prev_ss && !ss_n1) begin
                if (nf < 2) falls[nf] = c;
                nf++;
                if (nf == 2) bus1.cmd_valid = 1'b0;
            end
            if (sclk1 && !prev_sc && nf >= 1 && nf <= 2) begin
                got_w[nf - 1] = {got_w[nf - 1][30:0], mosi1};
            end
            if (bus1.busy && bus1.cmd_ready) viol++;
            prev_ss = ss_n1;
            prev_sc = sclk1;
            if (c <= 60) begin
                bus1.cmd_valid = 1'($urandom_range(0, 1));
                bus1.cmd_data  = $urandom;
            end else if (c == 61) begin
                bus1.cmd_valid = 1'b1;
                bus1.cmd_data  = word_b;
            end
        end
        bus1.cmd_valid = 1'b0;
        checks++;
        if (nf != 2 || (falls[1] - falls[0]) != 69) begin
            errors++;
            $display("[TB] FAIL b2b_period frames=%0d gap=%0d exp frames=2 gap=69", nf, falls[1] - falls[0]);
        end
        checks++;
        if (got_w[0] !== word_a || got_w[1] !== word_b) begin
            errors++;
            $display("[TB] FAIL b2b_words got=%h,%h exp=%h,%h", got_w[0], got_w[1], word_a, word_b);
        end
        checks++;
        if (viol != 0) begin
            errors++;
            $display("[TB] FAIL b2b_ready_while_busy got=%0d exp=0", viol);
        end
    endtask

    task automatic test_reset_abort();
        int         rises;
        int         latches;
        int         valids;
        logic       prev_sc;
        logic       hit;
        logic [4:0] got;
        rises   = 0;
        latches = 0;
        valids  = 0;
        prev_sc = 1'b0;
        hit     = 1'b0;
        @(negedge clock);
        bus4.cmd_data  = $urandom;
        bus4.cmd_valid = 1'b1;
        @(posedge clock);
        for (int c = 0; c < 200 && !hit; c++) begin
            @(negedge clock);
            bus4.cmd_valid = 1'b0;
            if (sclk4 && !prev_sc) rises++;
            prev_sc = sclk4;
            if (rises == 10) begin
                hit   = 1'b1;
                reset = 1'b1;
            end
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("[TB] FAIL abort_reach_bit got=%0d exp=10", rises);
        end
        @(negedge clock);
        reset = 1'b0;
        got = {ss_n4, sclk4, mosi4, latch4, bus4.rx_valid};
        checks++;
        if (got !== 5'b10000) begin
            errors++;
            $display("[TB] FAIL abort_pins got=%b exp=10000", got);
        end
        for (int c = 0; c < 400; c++) begin
            @(negedge clock);
            if (latch4) latches++;
            if (bus4.rx_valid) valids++;
        end
        checks++;
        if (latches != 0 || valids != 0 || bus4.rx_data !== 32'd0 || bus4.cmd_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL abort_after latch=%0d rxv=%0d rx=%h ready=%b exp 0 0 0 1",
                     latches, valids, bus4.rx_data, bus4.cmd_ready);
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        reset            = 1'b1;
        loop_en          = 1'b0;
        miso_rand        = 1'b0;
        miso1            = 1'b0;
        bus4.cmd_data    = 32'd0;
        bus4.cmd_valid   = 1'b0;
        bus4.trigger_req = 1'b0;
        bus1.cmd_data    = 32'd0;
        bus1.cmd_valid   = 1'b0;
        bus1.trigger_req = 1'b0;

        test_reset();
        test_single_frame();
        test_loopback();
        test_random_frames();
        test_trigger_idle();
        test_trigger_midframe();
        test_back_to_back();
        test_reset_abort();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
